// File: rtl/bus_sequencer_if.sv
// ---------------------------------------------------------------------------
// bus_sequencer_if
// Register-file side bus of the bus sequencer.
//
// Signals:
//   INST      [7:0] instruction word addressed by the PC ([7:4] opcode, [3:0] imm)
//   LOADBUS   [3:0] data driven back by the register-file tristates
//   STOREBUS  [3:0] store data towards the register file (mirrors accumulator)
//   nPC_LD          active-low PC load (jump)
//   nPC_OPEN        active-low PC increment
//   nJRD_ST/nJRU_ST/nORD_ST/nORU_ST     active-low register store strobes
//   nJRD_OUT/nJRU_OUT/nIRD_OUT/nIRU_OUT active-low register output enables
//
// Modports:
//   master : sequencer side (drives strobes and STOREBUS)
//   slave  : register-file / program-memory side
// ---------------------------------------------------------------------------
interface bus_sequencer_if;
   logic [7:0] INST;
   logic [3:0] LOADBUS;
   logic [3:0] STOREBUS;
   logic       nPC_LD;
   logic       nPC_OPEN;
   logic       nJRD_ST;
   logic       nJRU_ST;
   logic       nORD_ST;
   logic       nORU_ST;
   logic       nJRD_OUT;
   logic       nJRU_OUT;
   logic       nIRD_OUT;
   logic       nIRU_OUT;

   modport master (
      input  INST, LOADBUS,
      output STOREBUS, nPC_LD, nPC_OPEN,
             nJRD_ST, nJRU_ST, nORD_ST, nORU_ST,
             nJRD_OUT, nJRU_OUT, nIRD_OUT, nIRU_OUT
   );

   modport slave (
      output INST, LOADBUS,
      input  STOREBUS, nPC_LD, nPC_OPEN,
             nJRD_ST, nJRU_ST, nORD_ST, nORU_ST,
             nJRD_OUT, nJRU_OUT, nIRD_OUT, nIRU_OUT
   );
endinterface

// File: rtl/bus_sequencer.sv
// ---------------------------------------------------------------------------
// bus_sequencer
// Three-cycle instruction sequencer (FETCH -> EXEC -> NEXT) driving the
// active-low strobes of a 4-bit register file, with accumulator A and an
// optional carry/ALU path.
//
// Parameters:
//   ACC_RESET  reset value of accumulator A
//
// Ports:
//   CLK    single clock, rising edge
//   RST    synchronous active-high reset
//   RUN    1 = execute, 0 = halt at next FETCH
//   bus    bus_sequencer_if.master (INST, LOADBUS, STOREBUS, ten strobes)
//   ACC    accumulator A
//   CARRY  carry flag C
//   BUSY   high in any state other than FETCH
//
// Configuration macro:
//   BUS_SEQ_ALU_EN  defined   -> ADDI (opcode B) and JNC (opcode C) active
//                   undefined -> B and C execute as NOP, CARRY stays 0
// ---------------------------------------------------------------------------
module bus_sequencer #(
   parameter logic [3:0] ACC_RESET = 4'h0
) (
   input  logic                   CLK,
   input  logic                   RST,
   input  logic                   RUN,
   bus_sequencer_if.master        bus,
   output logic [3:0]             ACC,
   output logic                   CARRY,
   output logic                   BUSY
);

   typedef enum logic [1:0] {
      S_FETCH,
      S_EXEC,
      S_NEXT
   } state_t;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_LDI  = 4'h1,
      OP_STJD = 4'h2,
      OP_STJU = 4'h3,
      OP_STOD = 4'h4,
      OP_STOU = 4'h5,
      OP_LDJD = 4'h6,
      OP_LDJU = 4'h7,
      OP_LDID = 4'h8,
      OP_LDIU = 4'h9,
      OP_JMP  = 4'hA,
      OP_ADDI = 4'hB,
      OP_JNC  = 4'hC
   } op_t;

   // Bit positions inside the packed active-low strobe register.
   localparam int unsigned SB_PC_LD   = 0;
   localparam int unsigned SB_PC_OPEN = 1;
   localparam int unsigned SB_JRD_ST  = 2;
   localparam int unsigned SB_JRU_ST  = 3;
   localparam int unsigned SB_ORD_ST  = 4;
   localparam int unsigned SB_ORU_ST  = 5;
   localparam int unsigned SB_JRD_OUT = 6;
   localparam int unsigned SB_JRU_OUT = 7;
   localparam int unsigned SB_IRD_OUT = 8;
   localparam int unsigned SB_IRU_OUT = 9;

   state_t     r_state;
   logic [7:0] r_ireg;
   logic [3:0] r_a;
   logic       r_c;
   logic       r_busy;
   logic [9:0] r_strb;        // active-low, one bit per strobe

   op_t        w_fetch_op;
   op_t        w_exec_op;
   logic [9:0] w_exec_strb;   // strobe pattern for the coming EXEC cycle

   assign w_fetch_op = op_t'(bus.INST[7:4]);
   assign w_exec_op  = op_t'(r_ireg[7:4]);

`ifdef BUS_SEQ_ALU_EN
   logic [4:0] w_sum;
   assign w_sum = {1'b0, r_a} + {1'b0, r_ireg[3:0]};
`endif

   // Decode from INST during FETCH so the EXEC strobe comes straight out of
   // a flop on the first EXEC cycle. JNC looks at C as it stands at fetch,
   // which is the value the preceding instructions left behind.
   always_comb begin
      w_exec_strb = '1;
      case (w_fetch_op)
         OP_STJD: w_exec_strb[SB_JRD_ST]  = 1'b0;
         OP_STJU: w_exec_strb[SB_JRU_ST]  = 1'b0;
         OP_STOD: w_exec_strb[SB_ORD_ST]  = 1'b0;
         OP_STOU: w_exec_strb[SB_ORU_ST]  = 1'b0;
         OP_LDJD: w_exec_strb[SB_JRD_OUT] = 1'b0;
         OP_LDJU: w_exec_strb[SB_JRU_OUT] = 1'b0;
         OP_LDID: w_exec_strb[SB_IRD_OUT] = 1'b0;
         OP_LDIU: w_exec_strb[SB_IRU_OUT] = 1'b0;
         OP_JMP:  w_exec_strb[SB_PC_LD]   = 1'b0;
`ifdef BUS_SEQ_ALU_EN
         OP_JNC:  w_exec_strb[SB_PC_LD]   = r_c;
`endif
         default: w_exec_strb = '1;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_FETCH;
         r_ireg  <= 8'h00;
         r_a     <= ACC_RESET;
         r_c     <= 1'b0;
         r_busy  <= 1'b0;
         r_strb  <= '1;
      end else begin
         case (r_state)
            S_FETCH: begin
               r_strb <= '1;
               if (RUN) begin
                  r_ireg  <= bus.INST;
                  r_strb  <= w_exec_strb;
                  r_busy  <= 1'b1;
                  r_state <= S_EXEC;
               end
            end

            S_EXEC: begin
               case (w_exec_op)
                  OP_LDI:  r_a <= r_ireg[3:0];
                  OP_LDJD,
                  OP_LDJU,
                  OP_LDID,
                  OP_LDIU: r_a <= bus.LOADBUS;
`ifdef BUS_SEQ_ALU_EN
                  OP_ADDI: {r_c, r_a} <= w_sum;
`endif
                  default: ;
               endcase
               // A jump taken in EXEC (nPC_LD low) suppresses the increment.
               r_strb             <= '1;
               r_strb[SB_PC_OPEN] <= ~r_strb[SB_PC_LD];
               r_state            <= S_NEXT;
            end

            S_NEXT: begin
               r_strb  <= '1;
               r_busy  <= 1'b0;
               r_state <= S_FETCH;
            end

            default: begin
               r_strb  <= '1;
               r_busy  <= 1'b0;
               r_state <= S_FETCH;
            end
         endcase
      end
   end

   assign bus.STOREBUS = r_a;
   assign bus.nPC_LD   = r_strb[SB_PC_LD];
   assign bus.nPC_OPEN = r_strb[SB_PC_OPEN];
   assign bus.nJRD_ST  = r_strb[SB_JRD_ST];
   assign bus.nJRU_ST  = r_strb[SB_JRU_ST];
   assign bus.nORD_ST  = r_strb[SB_ORD_ST];
   assign bus.nORU_ST  = r_strb[SB_ORU_ST];
   assign bus.nJRD_OUT = r_strb[SB_JRD_OUT];
   assign bus.nJRU_OUT = r_strb[SB_JRU_OUT];
   assign bus.nIRD_OUT = r_strb[SB_IRD_OUT];
   assign bus.nIRU_OUT = r_strb[SB_IRU_OUT];

   assign ACC   = r_a;
   assign CARRY = r_c;
   assign BUSY  = r_busy;

endmodule

// File: doc/bus_sequencer.md
BUS_SEQUENCER -- requirements
Module: bus_sequencer

Interface
REQ-001 SHALL have parameter ACC_RESET, default 4'h0, reset value of accumulator A.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port RUN  input  1  high = execute; low = halt at next FETCH.
REQ-005 SHALL have port INST  input  8  instruction word addressed by PA; [7:4] opcode, [3:0] immediate.
REQ-006 SHALL have port LOADBUS  input  4  data returned by register file tristates.
REQ-007 SHALL have port STOREBUS  output  4  store data to register file; always equals A.
REQ-008 SHALL have ports nPC_LD, nPC_OPEN, nJRD_ST, nJRU_ST, nORD_ST, nORU_ST, nJRD_OUT, nJRU_OUT, nIRD_OUT, nIRU_OUT  output  1 each  active-low strobes to register file; nPC_OPEN low = PC increment.
REQ-009 SHALL have port ACC  output  4  accumulator A.
REQ-010 SHALL have port CARRY  output  1  carry flag C.
REQ-011 SHALL have port BUSY  output  1  high in any state other than FETCH.

Function
REQ-012 SHALL implement FSM FETCH -> EXEC -> NEXT -> FETCH; one instruction per 3 cycles.
REQ-013 FETCH: SHALL latch INST into IREG when RUN=1 and go to EXEC; RUN=0 stays FETCH, no strobes.
REQ-014 EXEC: SHALL hold exactly one strobe low per opcode (table below), or none; all others high.
REQ-015 Opcodes: 0 NOP; 1 LDI A<=imm; 2 STJD nJRD_ST; 3 STJU nJRU_ST; 4 STOD nORD_ST; 5 STOU nORU_ST; 6 LDJD nJRD_OUT; 7 LDJU nJRU_OUT; 8 LDID nIRD_OUT; 9 LDIU nIRU_OUT; A JMP nPC_LD; B ADDI; C JNC; D-F NOP.
REQ-016 Stores (2-5): SHALL present A on STOREBUS during EXEC; target register captures on the edge ending EXEC.
REQ-017 Loads (6-9): SHALL capture LOADBUS into A on the edge ending EXEC, with the OUT strobe low the whole cycle.
REQ-018 ADDI: SHALL compute {C,A} <= A + imm (5-bit sum) at end of EXEC; 4'hF+1 gives A=0, C=1.
REQ-019 C SHALL change only on ADDI; all other opcodes leave C unchanged.
REQ-020 JNC: SHALL assert nPC_LD in EXEC only when C=0; with C=1 behaves as NOP.
REQ-021 NEXT: SHALL assert nPC_OPEN low one cycle unless nPC_LD was asserted in the preceding EXEC; no other strobes in NEXT.
REQ-022 RUN falling mid-instruction SHALL not abort it; halt takes effect at following FETCH.
REQ-023 At most one of the ten strobes SHALL be low in any cycle.

Reset
REQ-024 RST=1 at a rising edge SHALL force: state FETCH, all strobes high, A=ACC_RESET, C=0, IREG=8'h00, BUSY=0.
REQ-025 RST asserted in EXEC or NEXT SHALL abandon the instruction; no strobe low in the cycle after the reset edge; no PC increment.
REQ-026 RST SHALL take priority over RUN and every opcode.

Configuration
REQ-027 Macro BUS_SEQ_ALU_EN defined: ADDI and JNC SHALL behave per REQ-018..REQ-020.
REQ-028 BUS_SEQ_ALU_EN undefined: opcodes B and C SHALL execute as NOP; C and CARRY SHALL be constant 0.

Verification
REQ-029 Reset then RUN=1, INST=8'h17 -> A=4'h7 after EXEC; nPC_OPEN low exactly in cycle 3; BUSY pattern 0,1,1.
REQ-030 A=4'h9, INST=8'h40 -> nORD_ST low exactly one cycle with STOREBUS=4'h9; no other strobe low.
REQ-031 INST=8'h80, LOADBUS=4'h5 in EXEC -> nIRD_OUT low one cycle; A=4'h5 afterwards.
REQ-032 A=4'hE, INST=8'hB3 -> A=4'h1, C=1; then INST=8'hC0 -> no nPC_LD, nPC_OPEN pulsed; ALU_EN off -> A=4'hE, C=0.
REQ-033 INST=8'hA0 -> nPC_LD low in EXEC, nPC_OPEN stays high in NEXT.
REQ-034 RST pulsed during EXEC of 8'h20 -> nJRD_ST high from the next cycle on, A=ACC_RESET, state FETCH.
